// File: rtl/nlynx_snapshot_fifo.sv
// nlynx_snapshot_fifo: snapshots metric counters on eop rising edge and streams each snapshot as a word-serial packet
// Optional NLYNX_SNAPSHOT_TIMESTAMP_EN adds a cycle-count word after the header.
module nlynx_snapshot_fifo #(
  parameter int NLYNX_METRICS       = 13,
  parameter int NLYNX_COUNTER_WIDTH = 32,
  parameter int DEPTH               = 4
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [NLYNX_METRICS*NLYNX_COUNTER_WIDTH-1:0] cnt_i,
  input  logic [NLYNX_METRICS-1:0]                     overflow_i,
  input  logic                                         eop_i,
  output logic [NLYNX_COUNTER_WIDTH-1:0]               m_data_o,
  output logic                                         m_valid_o,
  output logic                                         m_last_o,
  input  logic                                         m_ready_i,
  output logic [$clog2(DEPTH):0]                       fill_o,
  output logic                                         dropped_o,
  output logic [7:0]                                   drop_cnt_o
);
  localparam int M = NLYNX_METRICS;
  localparam int W = NLYNX_COUNTER_WIDTH;
`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
  localparam int H = 2;
`else
  localparam int H = 1;
`endif
  localparam int PKT = M + H;
  localparam int PW  = $clog2(DEPTH);
  localparam int FW  = PW + 1;
  localparam int IW  = $clog2(PKT);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(PKT - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t        state;
  logic [W-1:0]  mem [DEPTH][PKT];
  logic [W-1:0]  snap [PKT];
  logic [W-1:0]  hdr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill, fill_nx;
  logic [IW-1:0] idx;
  logic [7:0]    seq, drop_cnt;
  logic          eop_q, dropped, trig, pop, push;
  assign trig      = eop_i & ~eop_q;
  assign m_valid_o = state == SEND;
  assign m_last_o  = m_valid_o && idx == LAST;
  assign m_data_o  = m_valid_o ? mem[rd_ptr][idx] : '0;
  assign pop       = m_valid_o & m_ready_i & m_last_o;
  // A full FIFO still accepts when the head packet completes on this same edge.
  assign push      = trig & ((fill < FULL) | pop);
  assign fill_nx   = fill + FW'(push) - FW'(pop);
  assign fill_o     = fill;
  assign dropped_o  = dropped;
  assign drop_cnt_o = drop_cnt;
  always_comb begin
    hdr = '0;
    hdr[W-1 -: 8] = seq;
    hdr[M-1:0] = overflow_i;
  end
  assign snap[0] = hdr;
  for (genvar k = 0; k < M; k++) begin : g_snap
    assign snap[k+H] = cnt_i[k*W +: W];
  end
`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
  logic [31:0] ts;
  always_ff @(posedge clk_i) ts <= rst_i ? 32'd0 : ts + 32'd1;
  assign snap[1] = W'(ts);
`endif
  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= snap;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      idx      <= '0;
      seq      <= '0;
      drop_cnt <= '0;
      dropped  <= 1'b0;
      eop_q    <= 1'b0;
    end else begin
      eop_q <= eop_i;
      fill  <= fill_nx;
      if (trig) seq <= seq + 8'd1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (trig & ~push) begin
        dropped  <= 1'b1;
        drop_cnt <= drop_cnt + {7'd0, drop_cnt != 8'hff};
      end
      if (state == IDLE) begin
        idx   <= '0;
        state <= fill != '0 ? SEND : IDLE;
      end else if (m_ready_i) begin
        idx <= m_last_o ? '0 : idx + IW'(1);
        if (m_last_o) begin
          rd_ptr <= rd_ptr + PW'(1);
          state  <= fill_nx != '0 ? SEND : IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_nlynx_snapshot_fifo.sv
// tb_nlynx_snapshot_fifo: randomized and directed checks of nlynx_snapshot_fifo against a packet-queue model
module tb_nlynx_snapshot_fifo;
  localparam int M = 13;
  localparam int W = 32;
  localparam int DEPTH = 4;
`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
  localparam int PKT = M + 2;
`else
  localparam int PKT = M + 1;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1, eop_i = 1'b0, m_ready_i = 1'b0;
  logic [M*W-1:0] cnt_i = '0;
  logic [M-1:0] overflow_i = '0;
  logic [W-1:0] m_data_o;
  logic m_valid_o, m_last_o, dropped_o;
  logic [2:0] fill_o;
  logic [7:0] drop_cnt_o;

  nlynx_snapshot_fifo #(.NLYNX_METRICS(M), .NLYNX_COUNTER_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cnt_i(cnt_i), .overflow_i(overflow_i), .eop_i(eop_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
    .fill_o(fill_o), .dropped_o(dropped_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, failures = 0;
  logic [W-1:0] exp_words[$];
  int fill_m = 0, wpos = 0, drop_m = 0;
  logic [7:0] seq_m = 8'd0;
  bit dropped_m = 0, eop_prev = 0, stall_prev = 0;
  logic [31:0] ts_m = 32'd0;
  logic s_v, s_l, s_dropped;
  logic [W-1:0] s_d, e_d;
  logic [2:0] s_fill;
  logic [7:0] s_drop;
  bit e_l, e_any, e_dropped, was_stall;
  int e_fill, e_drop;

  // One clock: sample outputs and expectations at negedge, then advance the model past posedge.
  task automatic cyc();
    bit hs, pl, tr, acc;
    logic [M*W-1:0] c;
    logic [M-1:0] ov;
    @(negedge clk_i);
    s_v = m_valid_o; s_d = m_data_o; s_l = m_last_o;
    s_fill = fill_o; s_drop = drop_cnt_o; s_dropped = dropped_o;
    e_any = exp_words.size() > 0;
    e_d = e_any ? exp_words[0] : '0;
    e_l = (wpos == PKT - 1);
    e_fill = fill_m; e_drop = drop_m; e_dropped = dropped_m;
    was_stall = stall_prev;
    stall_prev = s_v & ~m_ready_i;
    hs = s_v & m_ready_i;
    pl = hs & e_l;
    tr = eop_i & ~eop_prev;
    acc = tr && (fill_m < DEPTH || pl);
    c = cnt_i; ov = overflow_i;
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      exp_words.delete();
      fill_m = 0; wpos = 0; drop_m = 0; seq_m = 8'd0; dropped_m = 0;
      eop_prev = 0; stall_prev = 0; ts_m = 32'd0;
    end else begin
      if (hs && e_any) begin
        void'(exp_words.pop_front());
        wpos = e_l ? 0 : wpos + 1;
        if (e_l) fill_m--;
      end
      if (tr) begin
        if (acc) begin
          exp_words.push_back({seq_m, 24'h0} | 32'(ov));
`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
          exp_words.push_back(ts_m);
`endif
          for (int k = 0; k < M; k++) exp_words.push_back(c[k*W +: W]);
          fill_m++;
        end else begin
          dropped_m = 1;
          if (drop_m < 255) drop_m++;
        end
        seq_m = seq_m + 8'd1;
      end
      eop_prev = eop_i;
      ts_m = ts_m + 32'd1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; eop_i = 1'b0; m_ready_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; eop_i = 1'b1; m_ready_i = 1'b0;
    cyc(); cyc();
    checks++;
    if ({s_v, s_l, s_d, s_fill, s_dropped, s_drop} !== '0) begin
      failures++;
      $display("FAIL reset_state valid=%b last=%b data=%h fill=%0d dropped=%b drop_cnt=%0d expected all zero", s_v, s_l, s_d, s_fill, s_dropped, s_drop);
    end
    rst_i = 1'b0;
    cyc(); cyc();
    checks++;
    if (s_fill !== 3'd1) begin failures++; $display("FAIL reset_eop_held fill=%0d expected 1", s_fill); end
    eop_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 100 && exp_words.size() > 0; i++) begin
      cyc();
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL reset_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
      end
    end
    checks++;
    if (exp_words.size() != 0) begin failures++; $display("FAIL reset_drain left=%0d expected 0", exp_words.size()); end
  endtask

  task automatic test_basic();
    int n = 0, iters = 0;
    bit first_ok = 0;
    do_reset();
    for (int k = 0; k < M; k++) cnt_i[k*W +: W] = 32'h100 + 32'(k);
    overflow_i = 13'h0005; m_ready_i = 1'b1;
    cyc();
    eop_i = 1'b1; cyc(); eop_i = 1'b0;
    cyc();
    checks++;
    if (s_v !== 1'b0 || s_fill !== 3'd1) begin failures++; $display("FAIL basic_capture valid=%b fill=%0d expected valid=0 fill=1", s_v, s_fill); end
    for (int i = 0; i < 100 && exp_words.size() > 0; i++) begin
      cyc();
      iters++;
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL basic_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
        if (n == 0 && i == 0 && s_d === 32'h0000_0005) first_ok = 1;
        n++;
      end
    end
    checks++;
    if (!first_ok || n != PKT || iters != PKT) begin
      failures++;
      $display("FAIL basic_packet header_ok=%b words=%0d cycles=%0d expected header 00000005 first cycle and %0d words in %0d cycles", first_ok, n, iters, PKT, PKT);
    end
    cyc();
    checks++;
    if (s_fill !== 3'd0 || s_v !== 1'b0) begin failures++; $display("FAIL basic_empty fill=%0d valid=%b expected 0 0", s_fill, s_v); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < M; k++) cnt_i[k*W +: W] = $urandom();
    overflow_i = 13'($urandom());
    cyc();
    eop_i = 1'b1; cyc(); eop_i = 1'b0;
    for (int i = 0; i < 200 && exp_words.size() > 0; i++) begin
      m_ready_i = ~m_ready_i;
      cyc();
      if (was_stall) begin
        checks++;
        if (!s_v) begin failures++; $display("FAIL stall_withdrawn valid=%b expected 1", s_v); end
      end
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL stall_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
      end
    end
    checks++;
    if (exp_words.size() != 0) begin failures++; $display("FAIL stall_drain left=%0d expected 0", exp_words.size()); end
  endtask

  task automatic test_overflow();
    int n = 0, iters = 0;
    do_reset();
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < M; k++) cnt_i[k*W +: W] = $urandom();
      eop_i = 1'b1; cyc(); eop_i = 1'b0; cyc();
    end
    cyc();
    checks++;
    if (s_fill !== 3'd4 || s_dropped !== 1'b1 || s_drop !== 8'd2) begin
      failures++;
      $display("FAIL overflow_state fill=%0d dropped=%b drop_cnt=%0d expected 4 1 2", s_fill, s_dropped, s_drop);
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < 200 && exp_words.size() > 0; i++) begin
      cyc();
      iters++;
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL overflow_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
        if (n % PKT == 0) begin
          checks++;
          if (s_d[W-1 -: 8] !== 8'(n / PKT)) begin failures++; $display("FAIL overflow_seq seq=%0d expected %0d", s_d[W-1 -: 8], n / PKT); end
        end
        n++;
      end
    end
    checks++;
    if (iters != 4 * PKT || n != 4 * PKT) begin failures++; $display("FAIL overflow_b2b words=%0d cycles=%0d expected %0d", n, iters, 4 * PKT); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < M; k++) cnt_i[k*W +: W] = $urandom();
      eop_i = 1'b1; cyc(); eop_i = 1'b0; cyc();
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < PKT - 1; i++) begin
      cyc();
      checks++;
      if (!s_v || !e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL simul_word valid=%b data=%h last=%b expected %h last=%b", s_v, s_d, s_l, e_d, e_l); end
    end
    eop_i = 1'b1; cyc(); eop_i = 1'b0;
    checks++;
    if (s_v !== 1'b1 || s_l !== 1'b1) begin failures++; $display("FAIL simul_last valid=%b last=%b expected 1 1", s_v, s_l); end
    cyc();
    checks++;
    if (s_fill !== 3'd4 || s_drop !== 8'd0 || s_dropped !== 1'b0) begin
      failures++;
      $display("FAIL simul_accept fill=%0d drop_cnt=%0d dropped=%b expected 4 0 0", s_fill, s_drop, s_dropped);
    end
    for (int i = 0; i < 200 && exp_words.size() > 0; i++) begin
      cyc();
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL simul_drain data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
      end
    end
    checks++;
    if (exp_words.size() != 0) begin failures++; $display("FAIL simul_left left=%0d expected 0", exp_words.size()); end
  endtask

  task automatic test_reset_mid();
    bit hdr_seen = 0;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      eop_i = 1'b1; cyc(); eop_i = 1'b0; cyc();
    end
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    cyc();
    checks++;
    if (s_v !== 1'b0 || s_fill !== 3'd0) begin failures++; $display("FAIL midreset_state valid=%b fill=%0d expected 0 0", s_v, s_fill); end
    for (int k = 0; k < M; k++) cnt_i[k*W +: W] = $urandom();
    eop_i = 1'b1; cyc(); eop_i = 1'b0;
    for (int i = 0; i < 100 && exp_words.size() > 0; i++) begin
      cyc();
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL midreset_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
        if (!hdr_seen) begin
          hdr_seen = 1;
          checks++;
          if (s_d[W-1 -: 8] !== 8'd0) begin failures++; $display("FAIL midreset_seq seq=%0d expected 0", s_d[W-1 -: 8]); end
        end
      end
    end
    checks++;
    if (exp_words.size() != 0 || !hdr_seen) begin failures++; $display("FAIL midreset_drain left=%0d seen=%b expected 0 1", exp_words.size(), hdr_seen); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      eop_i = $urandom_range(0, 5) == 0;
      m_ready_i = $urandom_range(0, 3) != 0;
      for (int k = 0; k < M; k++) cnt_i[k*W +: W] = $urandom();
      overflow_i = 13'($urandom());
      cyc();
      checks++;
      if (s_fill !== 3'(e_fill) || s_drop !== 8'(e_drop) || s_dropped !== e_dropped) begin
        failures++;
        $display("FAIL random_status fill=%0d drop_cnt=%0d dropped=%b expected %0d %0d %b", s_fill, s_drop, s_dropped, e_fill, e_drop, e_dropped);
      end
      if (was_stall && !s_v) begin failures++; $display("FAIL random_withdrawn valid=%b expected 1", s_v); end
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL random_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
      end
    end
    eop_i = 1'b0; m_ready_i = 1'b1;
    for (int i = 0; i < 200 && exp_words.size() > 0; i++) begin
      cyc();
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL random_drain data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
      end
    end
    checks++;
    if (exp_words.size() != 0) begin failures++; $display("FAIL random_left left=%0d expected 0", exp_words.size()); end
  endtask

`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
  task automatic test_timestamp();
    int n = 0;
    do_reset();
    for (int i = 0; i < 50; i++) cyc();
    eop_i = 1'b1; cyc(); eop_i = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 100 && exp_words.size() > 0; i++) begin
      cyc();
      if (s_v) begin
        checks++;
        if (!e_any || s_d !== e_d || s_l !== e_l) begin failures++; $display("FAIL ts_word data=%h last=%b expected %h last=%b", s_d, s_l, e_d, e_l); end
        if (n == 1) begin
          checks++;
          if (s_d < 32'd49 || s_d > 32'd51) begin failures++; $display("FAIL ts_value ts=%0d expected 50", s_d); end
        end
        n++;
      end
    end
    checks++;
    if (n != M + 2) begin failures++; $display("FAIL ts_length words=%0d expected %0d", n, M + 2); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_random();
`ifdef NLYNX_SNAPSHOT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
